// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mem_pkg
// Description : Store-control encodings, RMW state encoding and the store
//               misalignment predicate shared by the data-memory path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

  localparam logic [1:0] c_STORE_SB = 2'b00;
  localparam logic [1:0] c_STORE_SH = 2'b01;
  localparam logic [1:0] c_STORE_SW = 2'b10;

  localparam logic [0:0] c_STATE_IDLE  = 1'b0;
  localparam logic [0:0] c_STATE_MERGE = 1'b1;

  // The reserved encoding is rejected the same way as a misaligned access.
  function automatic logic isMisaligned(input logic [1:0] storeCtrl,
                                        input logic [1:0] byteOff);
    case (storeCtrl)
      c_STORE_SB: isMisaligned = 1'b0;
      c_STORE_SH: isMisaligned = byteOff[0];
      c_STORE_SW: isMisaligned = |byteOff;
      default:    isMisaligned = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_rmw_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : store_rmw_if
// Description : Pipeline store request and word-wide data RAM signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_rmw_if #(
  parameter int ADDR_W = 30
);

  logic              MemWriteM;
  logic [1:0]        StoreControlM;
  logic [31:0]       ALUResultM;
  logic [31:0]       WriteDataM;
  logic              StallM;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              StoreMisalignW;
  logic [15:0]       rmw_count;

  modport master (
    output MemWriteM, StoreControlM, ALUResultM, WriteDataM, ram_dout,
    input  StallM, ram_we, ram_addr, ram_din, StoreMisalignW, rmw_count
  );

  modport slave (
    input  MemWriteM, StoreControlM, ALUResultM, WriteDataM, ram_dout,
    output StallM, ram_we, ram_addr, ram_din, StoreMisalignW, rmw_count
  );

endinterface
`default_nettype wire

// File: rtl/store_rmw_unit_merge.sv
`default_nettype none
// ============================================================================
// Module      : store_merge
// Description : Combinational byte-lane merge of store data into a RAM word.
// Revision    : 1.0 - initial release
// ============================================================================
module store_merge
  import rv32_mem_pkg::*;
(
  input  logic [31:0] i_oldWord,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_oldWord;
    case (i_size)
      c_STORE_SB: begin
        case (i_offset)
          2'd0:    o_merged[7:0]   = i_data[7:0];
          2'd1:    o_merged[15:8]  = i_data[7:0];
          2'd2:    o_merged[23:16] = i_data[7:0];
          default: o_merged[31:24] = i_data[7:0];
        endcase
      end
      c_STORE_SH: begin
        if (i_offset[1]) o_merged[31:16] = i_data[15:0];
        else             o_merged[15:0]  = i_data[15:0];
      end
      c_STORE_SW: o_merged = i_data;
      default:    o_merged = i_oldWord;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_rmw_unit
// Description : M-stage store controller: SW pass-through, SB/SH via one-stall
//               read-modify-write, misaligned stores suppressed and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module store_rmw_unit
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic         CLK,
  input  logic         RST,
  store_rmw_if.slave   bus
);

  logic [0:0]        r_state;
  logic [1:0]        r_offset;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_wordAddr;
  logic [31:0]       r_data;
  logic              r_misalign;
  logic [15:0]       r_rmwCount;

  logic [ADDR_W-1:0] w_reqAddr;
  logic [1:0]        w_byteOff;
  logic              w_misalign;
  logic              w_isSw;
  logic              w_isRmw;
  logic [31:0]       w_merged;

  assign w_reqAddr  = bus.ALUResultM[ADDR_W+1:2];
  assign w_byteOff  = bus.ALUResultM[1:0];
  assign w_misalign = bus.MemWriteM && isMisaligned(bus.StoreControlM, w_byteOff);
  assign w_isSw     = bus.MemWriteM && !w_misalign && (bus.StoreControlM == c_STORE_SW);
  assign w_isRmw    = bus.MemWriteM && !w_misalign &&
                      ((bus.StoreControlM == c_STORE_SB) || (bus.StoreControlM == c_STORE_SH));

  store_merge u_merge (
    .i_oldWord (bus.ram_dout),
    .i_data    (r_data),
    .i_offset  (r_offset),
    .i_size    (r_size),
    .o_merged  (w_merged)
  );

  // Reset gates the write strobe so an RMW caught mid-flight never lands.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.StallM   = 1'b0;
    bus.ram_addr = w_reqAddr;
    bus.ram_din  = bus.WriteDataM;
    if (r_state == c_STATE_MERGE) begin
      bus.ram_addr = r_wordAddr;
      bus.ram_din  = w_merged;
      bus.ram_we   = !RST;
    end else if (!RST) begin
      bus.ram_we = w_isSw;
      bus.StallM = w_isRmw;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= c_STATE_IDLE;
      r_offset   <= '0;
      r_size     <= '0;
      r_wordAddr <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      r_rmwCount <= '0;
    end else begin
      case (r_state)
        c_STATE_IDLE: begin
          r_misalign <= w_misalign;
          if (w_isRmw) begin
            r_offset   <= w_byteOff;
            r_size     <= bus.StoreControlM;
            r_wordAddr <= w_reqAddr;
            r_data     <= bus.WriteDataM;
            r_state    <= c_STATE_MERGE;
          end
        end
        c_STATE_MERGE: begin
          r_misalign <= 1'b0;
          r_rmwCount <= r_rmwCount + 16'd1;
          r_state    <= c_STATE_IDLE;
        end
        default: r_state <= c_STATE_IDLE;
      endcase
    end
  end

  assign bus.StoreMisalignW = r_misalign;
  assign bus.rmw_count      = r_rmwCount;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_rmw_unit
// Description : Randomized self-checking bench for store_rmw_unit against a
//               byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_rmw_unit;

  localparam int c_ADDR_W = 30;

  logic CLK = 1'b1;
  logic RST;

  store_rmw_if #(.ADDR_W(c_ADDR_W)) bus ();

  store_rmw_unit #(.ADDR_W(c_ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read RAM covering byte addresses 0x100..0x1FF.
  logic [31:0] ram [0:63];
  always @(posedge CLK) begin
    if (bus.ram_we) ram[bus.ram_addr[5:0]] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr[5:0]];
  end

  logic [31:0] refMem [0:63];
  int          checks = 0;
  int          errors = 0;

  logic        chkEn = 1'b0;
  logic        chkAddr;
  logic        expWe, expStall, expMis;
  logic [31:0] expDin;
  logic [29:0] expAddr;
  logic [15:0] expCount;
  logic        pendMis = 1'b0;
  logic [15:0] modelCount = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chkEn) begin
      cmp("StallM", 32'(bus.StallM), 32'(expStall));
      cmp("ram_we", 32'(bus.ram_we), 32'(expWe));
      if (chkAddr) cmp("ram_addr", 32'(bus.ram_addr), 32'(expAddr));
      if (expWe)   cmp("ram_din", bus.ram_din, expDin);
      cmp("StoreMisalignW", 32'(bus.StoreMisalignW), 32'(expMis));
      cmp("rmw_count", 32'(bus.rmw_count), 32'(expCount));
    end
  end

  // One pipeline cycle: drive inputs, publish what the outputs must be.
  task automatic step(input logic rstV, input logic mw, input logic [1:0] ctrl,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic we, input logic stall, input logic [31:0] din,
                      input logic [29:0] waddr, input logic misNow, input logic cntInc);
    RST               = rstV;
    bus.MemWriteM     = mw;
    bus.StoreControlM = ctrl;
    bus.ALUResultM    = addr;
    bus.WriteDataM    = data;
    expWe    = we;
    expStall = stall;
    expDin   = din;
    expAddr  = waddr;
    chkAddr  = !rstV;
    expMis   = pendMis;
    expCount = modelCount;
    @(posedge CLK);
    #1;
    if (rstV) begin
      pendMis    = 1'b0;
      modelCount = '0;
    end else begin
      pendMis = misNow;
      if (cntInc) modelCount = modelCount + 16'd1;
    end
  endtask

  function automatic logic [31:0] randAddr();
    return 32'h100 + 32'($urandom_range(0, 255));
  endfunction

  task automatic idle();
    logic [31:0] a;
    a = randAddr();
    step(1'b0, 1'b0, 2'($urandom), a, $urandom, 1'b0, 1'b0, '0, a[31:2], 1'b0, 1'b0);
  endtask

  task automatic doReset();
    step(1'b1, 1'b0, 2'b00, 32'h100, '0, 1'b0, 1'b0, '0, 30'h40, 1'b0, 1'b0);
  endtask

  // Whole-instruction view: size/alignment rules and byte substitution.
  task automatic store(input logic [1:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] data, input bit rstInMerge);
    int          size;
    int          off;
    logic [5:0]  idx;
    logic [31:0] merged;
    logic [31:0] junkA;
    size = (ctrl == 2'b00) ? 1 : (ctrl == 2'b01) ? 2 : (ctrl == 2'b10) ? 4 : 0;
    off  = int'(addr[1:0]);
    idx  = addr[7:2];
    junkA = randAddr();
    if (size == 0 || (off % size) != 0) begin
      step(1'b0, 1'b1, ctrl, addr, data, 1'b0, 1'b0, '0, addr[31:2], 1'b1, 1'b0);
    end else if (size == 4) begin
      step(1'b0, 1'b1, ctrl, addr, data, 1'b1, 1'b0, data, addr[31:2], 1'b0, 1'b0);
      refMem[idx] = data;
    end else begin
      merged = refMem[idx];
      for (int b = 0; b < size; b++) merged[8*(off+b) +: 8] = data[8*b +: 8];
      step(1'b0, 1'b1, ctrl, addr, data, 1'b0, 1'b1, '0, addr[31:2], 1'b0, 1'b0);
      if (rstInMerge) begin
        step(1'b1, 1'($urandom), 2'($urandom), junkA, $urandom,
             1'b0, 1'b0, '0, addr[31:2], 1'b0, 1'b0);
      end else begin
        step(1'b0, 1'($urandom), 2'($urandom), junkA, $urandom,
             1'b1, 1'b0, merged, addr[31:2], 1'b0, 1'b1);
        refMem[idx] = merged;
      end
    end
  endtask

  initial begin
    bus.MemWriteM     = 1'b0;
    bus.StoreControlM = 2'b00;
    bus.ALUResultM    = 32'h100;
    bus.WriteDataM    = '0;
    doReset();
    chkEn = 1'b1;
    doReset();
    idle();

    for (int i = 0; i < 64; i++) store(2'b10, 32'h100 + 32'(4*i), $urandom, 1'b0);

    store(2'b10, 32'h100, 32'hDEADBEEF, 1'b0);
    cmp("sw_word", ram[0], 32'hDEADBEEF);
    store(2'b10, 32'h100, 32'h11223344, 1'b0);
    store(2'b00, 32'h102, 32'h000000AA, 1'b0);
    cmp("sb_word", ram[0], 32'h11AA3344);
    cmp("sb_count", 32'(bus.rmw_count), 32'd1);
    store(2'b01, 32'h102, 32'h0000BEEF, 1'b0);
    cmp("sh_hi_word", ram[0], 32'hBEEF3344);
    store(2'b01, 32'h100, 32'h0000CAFE, 1'b0);
    cmp("sh_lo_word", ram[0], 32'hBEEFCAFE);
    cmp("sh_count", 32'(bus.rmw_count), 32'd3);

    store(2'b01, 32'h101, 32'h12345678, 1'b0);
    idle();
    store(2'b10, 32'h102, 32'h87654321, 1'b0);
    idle();
    store(2'b11, 32'h100, 32'h55555555, 1'b0);
    idle();
    cmp("misalign_word", ram[0], 32'hBEEFCAFE);

    store(2'b00, 32'h103, 32'h00000077, 1'b1);
    cmp("abort_word", ram[0], 32'hBEEFCAFE);
    cmp("abort_count", 32'(bus.rmw_count), 32'd0);
    store(2'b10, 32'h104, 32'hA5A5A5A5, 1'b0);

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else store(2'($urandom), randAddr(), $urandom, $urandom_range(0, 32) == 0);
    end

    idle();
    force dut.r_rmwCount = 16'hFFFE;
    #1;
    release dut.r_rmwCount;
    modelCount = 16'hFFFE;
    store(2'b00, 32'h111, 32'h0000003C, 1'b0);
    store(2'b00, 32'h112, 32'h000000C3, 1'b0);
    idle();
    cmp("wrap_count", 32'(bus.rmw_count), 32'd0);

    for (int i = 0; i < 64; i++) cmp("final_mem", ram[i], refMem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-side access controller for the RV32I data memory, sitting in the M stage between the pipeline's store request signals and the word-wide single-port data RAM, which has one write-enable for the full word. Aligned SW stores pass through in one cycle. SB and SH stores are executed as a read-modify-write: read the word, merge the byte lanes, write it back, with the pipeline stalled for one cycle. Misaligned stores are suppressed and flagged.

## Interface
- ADDR_W, 30: word-address width driven to RAM (byte address bits [ADDR_W+1:2]).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- MemWriteM  in  1  store request valid this cycle.
- StoreControlM  in  2  00 SB, 01 SH, 10 SW, 11 reserved (treated as misaligned).
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-justified for SB/SH.
- StallM  out  1  combinational; high means the pipeline must hold M-stage inputs and bubble W.
- ram_we  out  1  RAM write-enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid one cycle after address (synchronous read).
- StoreMisalignW  out  1  registered one-cycle pulse on a suppressed store.
- rmw_count  out  16  registered count of completed RMW stores, wraps at 65535.

## Operation
- FSM states: IDLE, MERGE.
- IDLE, MemWriteM=0: ram_addr=ALUResultM[ADDR_W+1:2], ram_we=0, StallM=0. Load reads pass through unchanged.
- IDLE, SW with addr[1:0]=00: ram_we=1, ram_din=WriteDataM, StallM=0, stay in IDLE.
- IDLE, SB (any offset) or SH with addr[0]=0: ram_we=0, ram_addr=word address, StallM=1. Capture offset addr[1:0], word address, data and size into registers. Go to MERGE.
- MERGE: ram_addr=captured word address, ram_din=merge(ram_dout, captured data, offset, size), ram_we=1, StallM=0. rmw_count increments. Return to IDLE.
- Merge rule, SB: lane = offset; byte lane takes data[7:0]; the other bytes come from ram_dout.
- Merge rule, SH: offset[1]=0 replaces bits [15:0]; offset[1]=1 replaces bits [31:16]; the source is data[15:0].
- Misaligned (SH with addr[0]=1; SW with addr[1:0]≠00; StoreControlM=11): ram_we=0, StallM=0, stay in IDLE. StoreMisalignW=1 on the next cycle.
- The inputs sampled in MERGE are ignored; the pipeline is still holding the same instruction. A new request is accepted only in IDLE.

## Timing
- Reset values: state IDLE; StoreMisalignW=0; rmw_count=0; captured registers 0.
- Combinational outputs while RST=1: ram_we=0, StallM=0.
- SW latency: 0 stall cycles; write in the request cycle.
- SB/SH latency: exactly 1 stall cycle; write in the second cycle.
- Back-to-back SB/SH: each costs 2 cycles. A request in the cycle after MERGE is accepted normally.
- RMW followed by a load to the same word: the write happens in MERGE, and the load issues the following cycle. The RAM is read-after-write safe across cycles, so no forwarding is needed.
- RST asserted in MERGE: no write is issued in that cycle. The RMW is aborted, rmw_count is not incremented, and state returns to IDLE.
- rmw_count at 0xFFFF plus one RMW gives 0x0000.

## Structure
- Shared package rv32_mem_pkg holds:
  - StoreControl encodings SB/SH/SW (2-bit constants), shared with the decoder.
  - State encoding for IDLE/MERGE.
  - The misalignment predicate as a function.
- Sub-module store_merge: pure combinational lane merge. Inputs: old word, data, offset, size. Output: merged word. It is reused by the load-side extractor tests.

## Test plan
- SW 0xDEADBEEF to 0x100 → ram_we=1 in the same cycle, ram_addr=0x40, ram_din=0xDEADBEEF, StallM=0 throughout.
- Memory word 0x40=0x11223344; SB 0xAA to 0x102 → StallM=1 for one cycle, then write 0x11AA3344; rmw_count=1.
- Same word; SH 0xBEEF to 0x102 → write 0xBEEF3344. Then SH 0xCAFE to 0x100 → write 0xBEEFCAFE, 2 cycles each.
- SH to 0x101, and SW to 0x102 → no ram_we, StallM=0, StoreMisalignW pulses one cycle each time.
- SB to 0x103 with RST raised in the MERGE cycle → no write, word unchanged, rmw_count=0, state IDLE.
- Preload rmw_count near wrap with 65536 SB stores in total → count returns to 0.
